// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT FSM with prioritised redirects.
// Optional return-address stack is compiled in with `define PC_SEQ_RAS_EN.
module pc_sequencer #(
  parameter logic [9:0]  RESET_PC  = 10'd0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       branch_req,
  input  logic [9:0] branch_target,
  input  logic       jump_req,
  input  logic [9:0] jump_target,
  input  logic       call_req,
  input  logic       ret_req,
  input  logic       halt,
  input  logic       resume,
  output logic [9:0] pc_out,
  output logic       pc_valid,
  output logic [1:0] seq_state,
  output logic       ras_err
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t     state;
  logic [9:0] pc_inc;

  assign pc_inc    = pc_out + 10'd1;
  assign seq_state = state;

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [9:0]    ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] ptr_prev;
  logic [CW-1:0] ras_cnt;
  logic          push_en;
  logic          pop_en;
  logic          ras_err_q;

  // ras_ptr names the next free slot; wrapping on push discards the oldest entry
  assign ptr_next = (ras_ptr == PTR_LAST) ? '0 : ras_ptr + 1'b1;
  assign ptr_prev = (ras_ptr == '0) ? PTR_LAST : ras_ptr - 1'b1;
  assign push_en  = (state == RUN) && !halt && !jump_req && call_req;
  assign pop_en   = (state == RUN) && !halt && !jump_req && !call_req && ret_req;
  assign ras_err  = ras_err_q;

  always_ff @(posedge clk) begin
    if (push_en) ras_mem[ras_ptr] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr   <= '0;
      ras_cnt   <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= 1'b0;
      if (push_en) begin
        ras_ptr <= ptr_next;
        if (ras_cnt == CNT_FULL) ras_err_q <= 1'b1;
        else                     ras_cnt   <= ras_cnt + 1'b1;
      end else if (pop_en) begin
        if (ras_cnt == '0) begin
          ras_err_q <= 1'b1;
        end else begin
          ras_ptr <= ptr_prev;
          ras_cnt <= ras_cnt - 1'b1;
        end
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{call_req, ret_req, RAS_DEPTH[0]};
  assign ras_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_out   <= '0;
      pc_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_out   <= RESET_PC;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt) begin
            state    <= HALT;
            pc_valid <= 1'b0;
          end else if (jump_req) begin
            pc_out <= jump_target;
`ifdef PC_SEQ_RAS_EN
          end else if (call_req) begin
            pc_out <= jump_target;
          end else if (ret_req) begin
            pc_out <= (ras_cnt == '0) ? pc_inc : ras_mem[ptr_prev];
`endif
          end else if (branch_req) begin
            pc_out <= branch_target;
          end else if (!stall) begin
            pc_out <= pc_inc;
          end
        end
        HALT: begin
          if (resume && !halt) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
